// File: rtl/inst_queue.sv
// Instruction queue between fetch and dual-slot decode: circular buffer of
// {instruction, PC} accepting 0-2 pushes and retiring 0-2 entries per cycle.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               push_valid,
  input  logic [31:0]              push_inst0,
  input  logic [31:0]              push_inst1,
  input  logic [XLEN-1:0]          push_pc0,
  input  logic [XLEN-1:0]          push_pc1,
  output logic                     push_ready,
  output logic                     valid_A,
  output logic                     valid_B,
  output logic [31:0]              inst_A,
  output logic [31:0]              inst_B,
  output logic [XLEN-1:0]          pc_A,
  output logic [XLEN-1:0]          pc_B,
  output logic [6:0]               opcode_A,
  output logic [2:0]               funct3_A,
  output logic [6:0]               funct7_A,
  output logic [6:0]               opcode_B,
  output logic [2:0]               funct3_B,
  output logic [6:0]               funct7_B,
  input  logic                     pop_A,
  input  logic                     pop_B,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head1;
  logic [PW-1:0] tail1;
  logic [1:0]    n_push;
  logic [1:0]    n_pop;

  always_comb begin
    // Ready depends only on registered count: no pop-to-ready combinational path.
    push_ready = (count <= READY_MAX);
    valid_A    = (count != '0);
    valid_B    = (count >= CW'(2));
    head1      = head + PW'(1);
    tail1      = tail + PW'(1);

    n_push = 2'd0;
    if (push_ready) begin
      case (push_valid)
        2'b01:   n_push = 2'd1;
        2'b11:   n_push = 2'd2;
        default: n_push = 2'd0;
      endcase
    end

    n_pop = {1'b0, pop_A & valid_A} + {1'b0, pop_A & pop_B & valid_B};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_pop);
      tail  <= tail + PW'(n_push);
      count <= count + CW'(n_push) - CW'(n_pop);
    end
  end

  // Storage is never cleared; the valids mask stale contents after reset/flush.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      if (n_push != 2'd0) begin
        inst_mem[tail] <= push_inst0;
        pc_mem[tail]   <= push_pc0;
      end
      if (n_push == 2'd2) begin
        inst_mem[tail1] <= push_inst1;
        pc_mem[tail1]   <= push_pc1;
      end
    end
  end

  always_comb begin
    inst_A   = valid_A ? inst_mem[head]  : '0;
    pc_A     = valid_A ? pc_mem[head]    : '0;
    inst_B   = valid_B ? inst_mem[head1] : '0;
    pc_B     = valid_B ? pc_mem[head1]   : '0;
    opcode_A = inst_A[6:0];
    funct3_A = inst_A[14:12];
    funct7_A = inst_A[31:25];
    opcode_B = inst_B[6:0];
    funct3_B = inst_B[14:12];
    funct7_B = inst_B[31:25];
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed vector table, fill/wrap
// sequence and randomized traffic against a queue-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  localparam logic [31:0] I_ADD  = 32'h0000_0033;
  localparam logic [31:0] I_ADDI = 32'h0000_0013;
  localparam logic [31:0] I_REMU = 32'h0200_F033;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [1:0]      push_valid;
  logic [31:0]     push_inst0, push_inst1;
  logic [XLEN-1:0] push_pc0, push_pc1;
  logic            push_ready;
  logic            valid_A, valid_B;
  logic [31:0]     inst_A, inst_B;
  logic [XLEN-1:0] pc_A, pc_B;
  logic [6:0]      opcode_A, funct7_A, opcode_B, funct7_B;
  logic [2:0]      funct3_A, funct3_B;
  logic            pop_A, pop_B;
  logic [$clog2(DEPTH):0] count;

  inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid),
    .push_inst0(push_inst0), .push_inst1(push_inst1),
    .push_pc0(push_pc0), .push_pc1(push_pc1),
    .push_ready(push_ready),
    .valid_A(valid_A), .valid_B(valid_B),
    .inst_A(inst_A), .inst_B(inst_B),
    .pc_A(pc_A), .pc_B(pc_B),
    .opcode_A(opcode_A), .funct3_A(funct3_A), .funct7_A(funct7_A),
    .opcode_B(opcode_B), .funct3_B(funct3_B), .funct7_B(funct7_B),
    .pop_A(pop_A), .pop_B(pop_B),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of resident entries, oldest first.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t q[$];

  task automatic step(input logic r, input logic f, input logic [1:0] pv,
                      input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1,
                      input logic pa, input logic pb);
    int sz;
    int np;
    bit rdy;
    ent_t e;
    rst_n = r; flush = f; push_valid = pv;
    push_inst0 = i0; push_pc0 = p0; push_inst1 = i1; push_pc1 = p1;
    pop_A = pa; pop_B = pb;
    @(posedge clk);
    #1;
    if (!r || f) begin
      q.delete();
    end else begin
      sz  = q.size();
      rdy = (DEPTH - sz) >= 2;
      np  = 0;
      if (pa && sz >= 1) np = 1;
      if (pa && pb && sz >= 2) np = 2;
      for (int k = 0; k < np; k++) void'(q.pop_front());
      if (rdy && pv[0]) begin e.inst = i0; e.pc = p0; q.push_back(e); end
      if (rdy && pv == 2'b11) begin e.inst = i1; e.pc = p1; q.push_back(e); end
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ea, eb, pa_e, pb_e;
    int sz;
    sz   = q.size();
    ea   = (sz >= 1) ? q[0].inst : 32'h0;
    pa_e = (sz >= 1) ? q[0].pc   : 32'h0;
    eb   = (sz >= 2) ? q[1].inst : 32'h0;
    pb_e = (sz >= 2) ? q[1].pc   : 32'h0;
    chk({tag, ".count"},      count,      sz);
    chk({tag, ".push_ready"}, push_ready, ((DEPTH - sz) >= 2));
    chk({tag, ".valid_A"},    valid_A,    (sz >= 1));
    chk({tag, ".valid_B"},    valid_B,    (sz >= 2));
    chk({tag, ".inst_A"},     inst_A,     ea);
    chk({tag, ".pc_A"},       pc_A,       pa_e);
    chk({tag, ".inst_B"},     inst_B,     eb);
    chk({tag, ".pc_B"},       pc_B,       pb_e);
    chk({tag, ".fields_A"},   {funct7_A, funct3_A, opcode_A}, {ea[31:25], ea[14:12], ea[6:0]});
    chk({tag, ".fields_B"},   {funct7_B, funct3_B, opcode_B}, {eb[31:25], eb[14:12], eb[6:0]});
  endtask

  typedef struct {
    logic r, f; logic [1:0] pv;
    logic [31:0] i0, p0, i1, p1;
    logic pa, pb;
    int cnt; logic va, vb;
    logic [31:0] ia, pca, ib, pcb;
    logic rdy;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic [1:0] pv,
                              logic [31:0] i0, logic [31:0] p0, logic [31:0] i1, logic [31:0] p1,
                              logic pa, logic pb, int cnt, logic va, logic vb,
                              logic [31:0] ia, logic [31:0] pca, logic [31:0] ib, logic [31:0] pcb,
                              logic rdy);
    vec_t v;
    v.r = r; v.f = f; v.pv = pv; v.i0 = i0; v.p0 = p0; v.i1 = i1; v.p1 = p1;
    v.pa = pa; v.pb = pb; v.cnt = cnt; v.va = va; v.vb = vb;
    v.ia = ia; v.pca = pca; v.ib = ib; v.pcb = pcb; v.rdy = rdy;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] pc_nx, head_pc, w0, w1;
    int exp_cnt, n;
    string tag;

    //            r f pv     i0      p0      i1      p1    pa pb  cnt va vb  ia      pcA     ib      pcB    rdy
    vecs.push_back(mk(0,0,2'b11,I_ADD, 32'h100,I_ADDI,32'h104,0,0, 0,0,0, 0,     0,      0,     0,      1));
    vecs.push_back(mk(0,0,2'b11,I_ADD, 32'h100,I_ADDI,32'h104,0,0, 0,0,0, 0,     0,      0,     0,      1));
    vecs.push_back(mk(1,0,2'b00,0,     0,      0,     0,      0,0, 0,0,0, 0,     0,      0,     0,      1));
    vecs.push_back(mk(1,0,2'b11,I_ADD, 32'h100,I_ADDI,32'h104,0,0, 2,1,1, I_ADD, 32'h100,I_ADDI,32'h104,1));
    vecs.push_back(mk(1,0,2'b01,I_REMU,32'h108,0,     0,      0,0, 3,1,1, I_ADD, 32'h100,I_ADDI,32'h104,1));
    vecs.push_back(mk(1,0,2'b00,0,     0,      0,     0,      1,1, 1,1,0, I_REMU,32'h108,0,     0,      1));
    vecs.push_back(mk(1,0,2'b00,0,     0,      0,     0,      0,1, 1,1,0, I_REMU,32'h108,0,     0,      1));
    vecs.push_back(mk(1,0,2'b11,I_ADD, 32'h10C,I_ADDI,32'h110,0,0, 3,1,1, I_REMU,32'h108,I_ADD, 32'h10C,1));
    vecs.push_back(mk(1,0,2'b00,0,     0,      0,     0,      1,0, 2,1,1, I_ADD, 32'h10C,I_ADDI,32'h110,1));
    vecs.push_back(mk(1,0,2'b10,I_REMU,32'h500,I_REMU,32'h504,0,0, 2,1,1, I_ADD, 32'h10C,I_ADDI,32'h110,1));
    vecs.push_back(mk(1,0,2'b00,0,     0,      0,     0,      1,0, 1,1,0, I_ADDI,32'h110,0,     0,      1));
    vecs.push_back(mk(1,0,2'b00,0,     0,      0,     0,      1,1, 0,0,0, 0,     0,      0,     0,      1));
    vecs.push_back(mk(1,0,2'b00,0,     0,      0,     0,      1,0, 0,0,0, 0,     0,      0,     0,      1));
    vecs.push_back(mk(1,0,2'b11,I_ADD, 32'h200,I_ADDI,32'h204,0,0, 2,1,1, I_ADD, 32'h200,I_ADDI,32'h204,1));
    vecs.push_back(mk(1,0,2'b11,I_REMU,32'h208,I_ADD, 32'h20C,0,0, 4,1,1, I_ADD, 32'h200,I_ADDI,32'h204,1));
    vecs.push_back(mk(1,1,2'b11,I_ADDI,32'h210,I_REMU,32'h214,1,0, 0,0,0, 0,     0,      0,     0,      1));
    vecs.push_back(mk(1,0,2'b01,I_REMU,32'h300,0,     0,      0,0, 1,1,0, I_REMU,32'h300,0,     0,      1));
    vecs.push_back(mk(1,0,2'b11,I_ADD, 32'h304,I_ADDI,32'h308,1,0, 2,1,1, I_ADD, 32'h304,I_ADDI,32'h308,1));
    vecs.push_back(mk(0,0,2'b11,I_ADD, 32'h400,I_ADDI,32'h404,1,1, 0,0,0, 0,     0,      0,     0,      1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].f, vecs[i].pv, vecs[i].i0, vecs[i].p0,
           vecs[i].i1, vecs[i].p1, vecs[i].pa, vecs[i].pb);
      tag = $sformatf("vec%0d", i);
      chk({tag, ".count"},      count,      vecs[i].cnt);
      chk({tag, ".valid_A"},    valid_A,    vecs[i].va);
      chk({tag, ".valid_B"},    valid_B,    vecs[i].vb);
      chk({tag, ".inst_A"},     inst_A,     vecs[i].ia);
      chk({tag, ".pc_A"},       pc_A,       vecs[i].pca);
      chk({tag, ".inst_B"},     inst_B,     vecs[i].ib);
      chk({tag, ".pc_B"},       pc_B,       vecs[i].pcb);
      chk({tag, ".push_ready"}, push_ready, vecs[i].rdy);
      chk({tag, ".fields_A"},   {funct7_A, funct3_A, opcode_A},
          {vecs[i].ia[31:25], vecs[i].ia[14:12], vecs[i].ia[6:0]});
      chk({tag, ".opcode_B"},   opcode_B,   vecs[i].ib[6:0]);
    end

    // Fill with an odd offset so the 2-entry push and pop straddle the wrap.
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    pc_nx = 32'h1000; head_pc = 32'h1000; exp_cnt = 0;
    w0 = $urandom;
    step(1, 0, 2'b01, w0, pc_nx, 0, 0, 0, 0);
    pc_nx += 4; exp_cnt = 1;
    chk("fill.count1", count, exp_cnt);
    for (int i = 0; i < 3; i++) begin
      w0 = $urandom; w1 = $urandom;
      step(1, 0, 2'b11, w0, pc_nx, w1, pc_nx + 4, 0, 0);
      pc_nx += 8; exp_cnt += 2;
      chk("fill.count", count, exp_cnt);
      chk("fill.ready", push_ready, (exp_cnt <= DEPTH - 2));
      check_model("fill");
    end
    chk("full.ready_at_7", push_ready, 1'b0);
    w0 = $urandom; w1 = $urandom;
    step(1, 0, 2'b11, w0, pc_nx, w1, pc_nx + 4, 0, 0);
    chk("full.push_dropped", count, 7);
    step(1, 0, 2'b11, w0, pc_nx, w1, pc_nx + 4, 1, 1);
    exp_cnt = 5; head_pc += 8;
    chk("full.pop_no_push", count, exp_cnt);
    chk("full.pc_A", pc_A, head_pc);
    check_model("full");
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 2'b11, w0, pc_nx, w1, pc_nx + 4, 1, 1);
      pc_nx += 8; head_pc += 8;
      w0 = $urandom; w1 = $urandom;
      chk("wrap.count", count, exp_cnt);
      chk("wrap.pc_A", pc_A, head_pc);
      chk("wrap.pc_B", pc_B, head_pc + 4);
      check_model("wrap");
    end
    for (int i = 0; i < DEPTH && exp_cnt > 0; i++) begin
      step(1, 0, 2'b00, 0, 0, 0, 0, 1, 1);
      n = (exp_cnt >= 2) ? 2 : 1;
      exp_cnt -= n; head_pc += 4 * n;
      chk("drain.count", count, exp_cnt);
      if (exp_cnt > 0) chk("drain.pc_A", pc_A, head_pc);
    end
    chk("drain.final_pc", head_pc, pc_nx);

    // Randomized traffic, including occasional flush and mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      logic r, f, pa, pb;
      logic [1:0] pv;
      r  = ($urandom_range(0, 63) != 0);
      f  = ($urandom_range(0, 31) == 0);
      pv = 2'($urandom_range(0, 3));
      pa = ($urandom_range(0, 2) != 0);
      pb = $urandom_range(0, 1);
      w0 = $urandom; w1 = $urandom;
      step(r, f, pv, w0, pc_nx, w1, pc_nx + 4, pa, pb);
      pc_nx += 8;
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
